// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter in front of a single shared uart_tx.
// Optional macro UART_ARB_FIXED_PRIO_EN: requester 0 always wins ties.

// Small synchronous FIFO, one per requester.
// The read data is combinational from the head slot.
module uart_tx_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // DEPTH is a power of two, so the count MSB is set only when full.
    assign ready = ~count[AW];
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array; pointer wrap is the natural modulo-DEPTH overflow.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_arb #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       tx_src,
    output logic       idle
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       push0;
    logic       push1;
    logic       pop0;
    logic       pop1;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic       empty0;
    logic       empty1;
    logic       grant;
    logic       grant_src;
    logic [7:0] data_q;
    logic       src_q;

    assign push0 = req0_valid & req0_ready;
    assign push1 = req1_valid & req1_ready;

    uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .din   (req0_data),
        .pop   (pop0),
        .dout  (dout0),
        .empty (empty0),
        .ready (req0_ready)
    );

    uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .din   (req1_data),
        .pop   (pop1),
        .dout  (dout1),
        .empty (empty1),
        .ready (req1_ready)
    );

`ifdef UART_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it has data.
    always_comb begin
        grant_src = empty0;
    end
`else
    logic rr;

    // Round-robin pick on a tie, otherwise whoever has data.
    always_comb begin
        grant_src = 1'b0;
        if (!empty0 && !empty1) begin
            grant_src = rr;
        end else begin
            grant_src = empty0;
        end
    end

    // After each grant the pointer moves to the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (grant) begin
            rr <= ~grant_src;
        end
    end
`endif

    // Next-state logic; a grant pops exactly one FIFO in IDLE.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pop0      = 1'b0;
        pop1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty0 || !empty1) begin
                    grant     = 1'b1;
                    pop0      = ~grant_src;
                    pop1      = grant_src;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte and owner latch, held stable until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 8'h00;
            src_q  <= 1'b0;
        end else if (grant) begin
            data_q <= grant_src ? dout1 : dout0;
            src_q  <= grant_src;
        end
    end

    assign tx_start = (state == ISSUE);
    assign tx_data  = data_q;
    assign tx_src   = src_q;
    assign idle     = (state == IDLE) && empty0 && empty1;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with a simple busy model
// standing in for the shared uart_tx.
`timescale 1ns/1ps
module tb_uart_tx_arb;
    localparam int BUSY_CYC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_src;
    logic       idle;

    logic force_busy = 1'b0;
    logic mbusy = 1'b0;
    logic no_ack = 1'b0;

    int total = 0;
    int bad = 0;
    logic [8:0] sb [$];

    assign tx_busy = force_busy | mbusy;

    always #5 clk = ~clk;

    uart_tx_arb #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_src     (tx_src),
        .idle       (idle)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    // uart_tx stand-in: raises busy for BUSY_CYC cycles per start.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mbusy = 1'b0;
            end else if (tx_start && !no_ack && !mbusy) begin
                mbusy = 1'b1;
                repeat (BUSY_CYC) @(negedge clk);
                mbusy = 1'b0;
            end
        end
    end

    // Monitor: every new start must match the head of the scoreboard.
    initial begin
        logic prev;
        logic [8:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (tx_start && !prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_tx act=%0h req=none",
                                 {tx_src, tx_data});
                    end else begin
                        exp = sb.pop_front();
                        chk("tx_byte", {23'd0, tx_src, tx_data},
                            {23'd0, exp});
                    end
                end
                prev = tx_start;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog act=running req=finished");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic push(input bit src, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        if (src) begin
            req1_valid = 1'b1;
            req1_data  = d;
        end else begin
            req0_valid = 1'b1;
            req0_data  = d;
        end
        while (!(src ? req1_ready : req0_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            chk("push_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        if (src) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle && !tx_busy && sb.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, n < 2000}, 32'd1);
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'h00);
        chk("rst_src", {31'd0, tx_src}, 32'd0);
        chk("rst_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("rst_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;

        // Single byte and first-start latency.
        sb.push_back(9'h0A5);
        push(1'b0, 8'hA5);
        @(negedge clk);
        chk("lat_pre", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk("lat_start", {31'd0, tx_start}, 32'd1);
        chk("lat_data", {24'd0, tx_data}, 32'hA5);
        chk("lat_src", {31'd0, tx_src}, 32'd0);
        drain("drain_a5");

        // Preload both requesters while the uart reports busy.
        force_busy = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
        sb.push_back(9'h011);
        sb.push_back(9'h022);
        sb.push_back(9'h133);
        sb.push_back(9'h144);
`else
        sb.push_back(9'h011);
        sb.push_back(9'h133);
        sb.push_back(9'h022);
        sb.push_back(9'h144);
`endif
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        push(1'b1, 8'h33);
        push(1'b1, 8'h44);
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        drain("drain_rr");

        // Fill req1 to DEPTH while stalled in WAIT_DONE.
        force_busy = 1'b1;
        sb.push_back(9'h05A);
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(9'h160 + 9'(i));
        end
        push(1'b0, 8'h5A);
        for (int i = 1; i <= 4; i++) begin
            push(1'b1, 8'h60 + 8'(i));
        end
        chk("full_rdy1", {31'd0, req1_ready}, 32'd0);
        fork
            push(1'b1, 8'h65);
            begin
                repeat (5) @(negedge clk);
                chk("held_rdy1", {31'd0, req1_ready}, 32'd0);
                force_busy = 1'b0;
            end
        join
        drain("drain_full");

        // No busy response: tx_start must hold and nothing else pops.
        no_ack = 1'b1;
        sb.push_back(9'h077);
        sb.push_back(9'h078);
        push(1'b0, 8'h77);
        push(1'b0, 8'h78);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start) cnt++;
        end
        chk("hold_cnt", cnt, 32'd50);
        chk("hold_data", {24'd0, tx_data}, 32'h77);
        chk("hold_idle", {31'd0, idle}, 32'd0);
        no_ack = 1'b0;
        drain("drain_hold");

        // Reset while in WAIT_DONE with two bytes queued.
        force_busy = 1'b1;
        sb.push_back(9'h081);
        push(1'b0, 8'h81);
        push(1'b0, 8'h82);
        push(1'b1, 8'h83);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_idle", {31'd0, idle}, 32'd1);
        chk("mid_rst_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("mid_rst_rdy1", {31'd0, req1_ready}, 32'd1);
        force_busy = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_idle", {31'd0, idle}, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
